// File: rtl/cache_pkg.sv
// Shared geometry, field helpers and FSM encoding for the cache controller slice.
// The cache geometry is fixed here so the interface, victim selector and controller always agree.
package cache_pkg;
  localparam int ADDRESS_WIDTH   = 32;
  localparam int SETS            = 1024;
  localparam int WAYS            = 2;
  localparam int CACHE_LINE_SIZE = 32;
  localparam int STROBE_WIDTH    = CACHE_LINE_SIZE / 8;
  localparam int OFFSET_BITS     = $clog2(CACHE_LINE_SIZE / 8);
  localparam int SET_BITS        = $clog2(SETS);
  localparam int TAG_WIDTH       = ADDRESS_WIDTH - SET_BITS - OFFSET_BITS;
  localparam int WAY_BITS        = $clog2(WAYS);

  typedef logic [ADDRESS_WIDTH-1:0]   addr_t;
  typedef logic [CACHE_LINE_SIZE-1:0] line_t;
  typedef logic [STROBE_WIDTH-1:0]    strobe_t;
  typedef logic [TAG_WIDTH-1:0]       tag_t;
  typedef logic [SET_BITS-1:0]        set_t;
  typedef logic [WAY_BITS-1:0]        way_t;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WRITEBACK, REFILL_REQ, REFILL_WAIT, REPLAY
  } state_t;

  function automatic tag_t addr_tag(input addr_t a);
    return a[ADDRESS_WIDTH-1 -: TAG_WIDTH];
  endfunction

  function automatic set_t addr_set(input addr_t a);
    return a[OFFSET_BITS +: SET_BITS];
  endfunction

  function automatic addr_t line_addr(input tag_t t, input set_t s);
    return {t, s, {OFFSET_BITS{1'b0}}};
  endfunction
endpackage

// File: rtl/cache_controller_if.sv
// CPU request/response and next-level memory line handshake bundled for the controller.
// master is the controller's view; slave is the CPU/memory environment's view.
interface cache_controller_if;
  import cache_pkg::*;

  logic    cpu_req_valid;
  logic    cpu_req_ready;
  addr_t   cpu_req_addr;
  logic    cpu_req_wen;
  line_t   cpu_req_wdata;
  strobe_t cpu_req_strobe;
  logic    cpu_resp_valid;
  line_t   cpu_resp_rdata;

  logic    mem_req_valid;
  logic    mem_req_ready;
  logic    mem_req_wen;
  addr_t   mem_req_addr;
  line_t   mem_req_wdata;
  logic    mem_resp_valid;
  line_t   mem_resp_rdata;

  modport master (
    input  cpu_req_valid, cpu_req_addr, cpu_req_wen, cpu_req_wdata, cpu_req_strobe,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    output cpu_req_valid, cpu_req_addr, cpu_req_wen, cpu_req_wdata, cpu_req_strobe,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/cache_victim_select.sv
// Victim choice for a miss: lowest-index invalid way, otherwise the set's round-robin pointer.
// The pointer of a set advances past the way that was just filled.
module cache_victim_select
  import cache_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  set_t            lookup_set,
  input  logic [WAYS-1:0] way_valid,
  input  logic            fill_en,
  input  set_t            fill_set,
  input  way_t            fill_way,
  output way_t            victim
);
  way_t rr_ptr [SETS];

  always_comb begin
    victim = rr_ptr[lookup_set];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) victim = way_t'(w);
    end
  end

  // NOTE: this pointer array is reset entry by entry so replacement order after rst is
  // deterministic; bulk storage such as CacheMemory is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
    end else if (fill_en) begin
      rr_ptr[fill_set] <= fill_way + way_t'(1);
    end
  end
endmodule

// File: rtl/cache_controller.sv
// Blocking write-back / write-allocate controller driving CacheMemory, one CPU request at a time.
// Lookup is issued the cycle a request is accepted and compared the cycle after.
module cache_controller
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  cache_controller_if.master bus,
  output logic               cm_req,
  output addr_t              cm_address,
  output line_t              cm_data_in,
  output strobe_t            cm_strobe,
  output logic [WAYS-1:0]    cm_wen_data,
  output logic [WAYS-1:0]    cm_wen_tag,
  output tag_t               cm_tag_in,
  output logic [1:0]         cm_valid_dirty_in  [WAYS],
  input  line_t              cm_data_out        [WAYS],
  input  tag_t               cm_tag_out         [WAYS],
  input  logic [1:0]         cm_valid_dirty_out [WAYS]
);
  state_t  state;
  addr_t   addr_q;
  logic    wen_q;
  line_t   wdata_q;
  strobe_t strobe_q;
  way_t    victim_q;
  tag_t    victim_tag_q;
  line_t   victim_line_q;

  tag_t            req_tag;
  set_t            req_set;
  logic            hit;
  way_t            hit_way;
  logic [WAYS-1:0] way_valid;
  way_t            victim;

  assign req_tag = addr_tag(addr_q);
  assign req_set = addr_set(addr_q);

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      way_valid[w] = cm_valid_dirty_out[w][0];
      if (cm_valid_dirty_out[w][0] && cm_tag_out[w] == req_tag) begin
        hit     = 1'b1;
        hit_way = way_t'(w);
      end
    end
  end

  cache_victim_select u_victim (
    .clk        (clk),
    .rst        (rst),
    .lookup_set (req_set),
    .way_valid  (way_valid),
    .fill_en    (!rst && state == REFILL_WAIT && bus.mem_resp_valid),
    .fill_set   (req_set),
    .fill_way   (victim_q),
    .victim     (victim)
  );

  // NOTE: request and victim registers carry no reset; each is loaded before any state reads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (bus.cpu_req_valid) begin
          addr_q   <= bus.cpu_req_addr;
          wen_q    <= bus.cpu_req_wen;
          wdata_q  <= bus.cpu_req_wdata;
          strobe_q <= bus.cpu_req_strobe;
          state    <= LOOKUP;
        end
        LOOKUP: if (hit) begin
          state <= IDLE;
        end else begin
          victim_q      <= victim;
          victim_tag_q  <= cm_tag_out[victim];
          victim_line_q <= cm_data_out[victim];
          state         <= (&cm_valid_dirty_out[victim]) ? WRITEBACK : REFILL_REQ;
        end
        WRITEBACK:   if (bus.mem_req_ready)  state <= REFILL_REQ;
        REFILL_REQ:  if (bus.mem_req_ready)  state <= REFILL_WAIT;
        REFILL_WAIT: if (bus.mem_resp_valid) state <= REPLAY;
        REPLAY:      state <= LOOKUP;
        default:     state <= IDLE;
      endcase
    end
  end

  // NOTE: outputs are decoded with blocking assignments from the registered state so a hit can
  // respond within the LOOKUP cycle; every output is defaulted first so no latch is inferred.
  always_comb begin
    bus.cpu_req_ready  = rst || state == IDLE;
    bus.cpu_resp_valid = 1'b0;
    bus.cpu_resp_rdata = '0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_req_wen    = 1'b0;
    bus.mem_req_addr   = '0;
    bus.mem_req_wdata  = '0;
    cm_req      = 1'b0;
    cm_address  = '0;
    cm_data_in  = '0;
    cm_strobe   = '0;
    cm_wen_data = '0;
    cm_wen_tag  = '0;
    cm_tag_in   = '0;
    for (int w = 0; w < WAYS; w++) cm_valid_dirty_in[w] = 2'b00;

    if (!rst) begin
      case (state)
        IDLE: if (bus.cpu_req_valid) begin
          cm_req     = 1'b1;
          cm_address = bus.cpu_req_addr;
        end
        LOOKUP: if (hit) begin
          bus.cpu_resp_valid = 1'b1;
          if (wen_q) begin
            cm_req                     = 1'b1;
            cm_address                 = addr_q;
            cm_data_in                 = wdata_q;
            cm_strobe                  = strobe_q;
            cm_wen_data[hit_way]       = 1'b1;
            cm_wen_tag[hit_way]        = 1'b1;
            cm_tag_in                  = req_tag;
            cm_valid_dirty_in[hit_way] = 2'b11;
          end else begin
            bus.cpu_resp_rdata = cm_data_out[hit_way];
          end
        end
        WRITEBACK: begin
          bus.mem_req_valid = 1'b1;
          bus.mem_req_wen   = 1'b1;
          bus.mem_req_addr  = line_addr(victim_tag_q, req_set);
          bus.mem_req_wdata = victim_line_q;
        end
        REFILL_REQ: begin
          bus.mem_req_valid = 1'b1;
          bus.mem_req_addr  = line_addr(req_tag, req_set);
        end
        REFILL_WAIT: if (bus.mem_resp_valid) begin
          cm_req                      = 1'b1;
          cm_address                  = addr_q;
          cm_data_in                  = bus.mem_resp_rdata;
          cm_strobe                   = '1;
          cm_wen_data[victim_q]       = 1'b1;
          cm_wen_tag[victim_q]        = 1'b1;
          cm_tag_in                   = req_tag;
          cm_valid_dirty_in[victim_q] = 2'b01;
        end
        REPLAY: begin
          cm_req     = 1'b1;
          cm_address = addr_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural 1-cycle-latency CacheMemory model.
// Sets 0x001 holds 0x1004/0x2004/0x3004/0x4004 so victim choice and writeback are exercised.
module tb_cache_controller;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_controller_if bus ();

  logic            cm_req;
  addr_t           cm_address;
  line_t           cm_data_in;
  strobe_t         cm_strobe;
  logic [WAYS-1:0] cm_wen_data;
  logic [WAYS-1:0] cm_wen_tag;
  tag_t            cm_tag_in;
  logic [1:0]      cm_valid_dirty_in  [WAYS];
  line_t           cm_data_out        [WAYS];
  tag_t            cm_tag_out         [WAYS];
  logic [1:0]      cm_valid_dirty_out [WAYS];

  cache_controller dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (bus),
    .cm_req             (cm_req),
    .cm_address         (cm_address),
    .cm_data_in         (cm_data_in),
    .cm_strobe          (cm_strobe),
    .cm_wen_data        (cm_wen_data),
    .cm_wen_tag         (cm_wen_tag),
    .cm_tag_in          (cm_tag_in),
    .cm_valid_dirty_in  (cm_valid_dirty_in),
    .cm_data_out        (cm_data_out),
    .cm_tag_out         (cm_tag_out),
    .cm_valid_dirty_out (cm_valid_dirty_out)
  );

  // CacheMemory stand-in: registered read of the addressed set, byte-strobed data writes.
  line_t      m_data [SETS][WAYS];
  tag_t       m_tag  [SETS][WAYS];
  logic [1:0] m_vd   [SETS][WAYS];

  always @(posedge clk) begin
    if (cm_req) begin
      for (int w = 0; w < WAYS; w++) begin
        cm_data_out[w]        <= m_data[addr_set(cm_address)][w];
        cm_tag_out[w]         <= m_tag[addr_set(cm_address)][w];
        cm_valid_dirty_out[w] <= m_vd[addr_set(cm_address)][w];
        if (cm_wen_tag[w]) begin
          m_tag[addr_set(cm_address)][w] <= cm_tag_in;
          m_vd[addr_set(cm_address)][w]  <= cm_valid_dirty_in[w];
        end
        if (cm_wen_data[w]) begin
          for (int b = 0; b < STROBE_WIDTH; b++) begin
            if (cm_strobe[b]) m_data[addr_set(cm_address)][w][8*b +: 8] <= cm_data_in[8*b +: 8];
          end
        end
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_accept(input string tag, input addr_t a, input logic w,
                            input line_t d, input strobe_t s);
    bus.cpu_req_valid  = 1'b1;
    bus.cpu_req_addr   = a;
    bus.cpu_req_wen    = w;
    bus.cpu_req_wdata  = d;
    bus.cpu_req_strobe = s;
    #1;
    check({tag, " accept ready"}, 64'(bus.cpu_req_ready), 64'd1);
    check({tag, " lookup cm_req"}, 64'(cm_req), 64'd1);
    check({tag, " lookup cm_address"}, 64'(cm_address), 64'(a));
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
  endtask

  task automatic mem_handshake(input string tag, input logic exp_wen, input addr_t exp_addr,
                               input line_t exp_wdata, input int stall);
    int n = 0;
    #1;
    while (!bus.mem_req_valid && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, " mem_req_valid"}, 64'(bus.mem_req_valid), 64'd1);
    check({tag, " mem_req_wen"}, 64'(bus.mem_req_wen), 64'(exp_wen));
    check({tag, " mem_req_addr"}, 64'(bus.mem_req_addr), 64'(exp_addr));
    if (exp_wen) check({tag, " mem_req_wdata"}, 64'(bus.mem_req_wdata), 64'(exp_wdata));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      #1;
      check({tag, " stall valid"}, 64'(bus.mem_req_valid), 64'd1);
      check({tag, " stall addr"}, 64'(bus.mem_req_addr), 64'(exp_addr));
      check({tag, " stall wdata"}, 64'(bus.mem_req_wdata), 64'(exp_wdata));
      check({tag, " stall cpu_req_ready"}, 64'(bus.cpu_req_ready), 64'd0);
    end
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
  endtask

  task automatic mem_refill(input string tag, input line_t d, input logic [WAYS-1:0] exp_way);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = d;
    #1;
    check({tag, " fill wen_data"}, 64'(cm_wen_data), 64'(exp_way));
    check({tag, " fill wen_tag"}, 64'(cm_wen_tag), 64'(exp_way));
    check({tag, " fill strobe"}, 64'(cm_strobe), 64'hF);
    for (int w = 0; w < WAYS; w++)
      check({tag, " fill vd_in"}, 64'(cm_valid_dirty_in[w]), exp_way[w] ? 64'd1 : 64'd0);
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
  endtask

  task automatic cpu_wait_resp(input string tag, input line_t exp, input int max);
    int n = 0;
    #1;
    while (!bus.cpu_resp_valid && n < max) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, " resp_valid"}, 64'(bus.cpu_resp_valid), 64'd1);
    check({tag, " resp_rdata"}, 64'(bus.cpu_resp_rdata), 64'(exp));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed hang expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_data[s][w] = '0;
        m_tag[s][w]  = '0;
        m_vd[s][w]   = 2'b00;
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      cm_data_out[w]        = '0;
      cm_tag_out[w]         = '0;
      cm_valid_dirty_out[w] = 2'b00;
    end
    rst                = 1'b1;
    bus.cpu_req_valid  = 1'b0;
    bus.cpu_req_addr   = '0;
    bus.cpu_req_wen    = 1'b0;
    bus.cpu_req_wdata  = '0;
    bus.cpu_req_strobe = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst cpu_req_ready", 64'(bus.cpu_req_ready), 64'd1);
    check("rst cm_req", 64'(cm_req), 64'd0);
    check("rst mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
    check("rst cpu_resp_valid", 64'(bus.cpu_resp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: cold read miss refilled into way0, then a 1-cycle hit
    cpu_accept("t1 miss", 32'h1004, 1'b0, '0, '0);
    mem_handshake("t1 refill", 1'b0, 32'h1004, '0, 0);
    mem_refill("t1", 32'hDEADBEEF, 2'b01);
    cpu_wait_resp("t1 miss", 32'hDEADBEEF, 4);
    cpu_accept("t1 hit", 32'h1004, 1'b0, '0, '0);
    #1;
    check("t1 hit resp_valid", 64'(bus.cpu_resp_valid), 64'd1);
    check("t1 hit rdata", 64'(bus.cpu_resp_rdata), 64'hDEADBEEF);
    check("t1 hit no mem", 64'(bus.mem_req_valid), 64'd0);
    @(negedge clk);
    #1;
    check("t1 back in idle", 64'(bus.cpu_req_ready), 64'd1);

    // 2: partial write hit merges two bytes and marks the line dirty
    cpu_accept("t2 write", 32'h1004, 1'b1, 32'h0000_1234, 4'b0011);
    #1;
    check("t2 wen_data", 64'(cm_wen_data), 64'b01);
    check("t2 wen_tag", 64'(cm_wen_tag), 64'b01);
    check("t2 vd_in way0", 64'(cm_valid_dirty_in[0]), 64'b11);
    check("t2 strobe", 64'(cm_strobe), 64'b0011);
    check("t2 data_in", 64'(cm_data_in), 64'h1234);
    check("t2 resp_valid", 64'(bus.cpu_resp_valid), 64'd1);
    check("t2 resp_rdata", 64'(bus.cpu_resp_rdata), 64'd0);
    @(negedge clk);
    check("t2 stored vd", 64'(m_vd[1][0]), 64'b11);
    cpu_accept("t2 read", 32'h1004, 1'b0, '0, '0);
    cpu_wait_resp("t2 read", 32'hDEAD1234, 0);

    // 3: fill way1, then a third tag evicts dirty way0 (with a 5-cycle stalled writeback)
    cpu_accept("t3 fill", 32'h2004, 1'b0, '0, '0);
    mem_handshake("t3 fill", 1'b0, 32'h2004, '0, 0);
    mem_refill("t3 fill", 32'hCAFEF00D, 2'b10);
    cpu_wait_resp("t3 fill", 32'hCAFEF00D, 4);
    cpu_accept("t3 evict", 32'h3004, 1'b0, '0, '0);
    mem_handshake("t4 writeback", 1'b1, 32'h1004, 32'hDEAD1234, 5);
    mem_handshake("t3 refill", 1'b0, 32'h3004, '0, 0);
    mem_refill("t3 refill", 32'h55AA55AA, 2'b01);
    cpu_wait_resp("t3 evict", 32'h55AA55AA, 4);

    // 5: reset while waiting for refill data; the late response must be ignored
    cpu_accept("t5 miss", 32'h4004, 1'b0, '0, '0);
    mem_handshake("t5 refill", 1'b0, 32'h4004, '0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst                = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'hFFFF_FFFF;
    #1;
    check("t5 late wen_data", 64'(cm_wen_data), 64'd0);
    check("t5 late wen_tag", 64'(cm_wen_tag), 64'd0);
    check("t5 late cm_req", 64'(cm_req), 64'd0);
    check("t5 idle ready", 64'(bus.cpu_req_ready), 64'd1);
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check("t5 way1 tag kept", 64'(m_tag[1][1]), 64'd2);
    cpu_accept("t5 re-miss", 32'h4004, 1'b0, '0, '0);
    mem_handshake("t5 re-miss", 1'b0, 32'h4004, '0, 0);
    mem_refill("t5 rr reset", 32'h0BADF00D, 2'b01);
    cpu_wait_resp("t5 re-miss", 32'h0BADF00D, 4);

    // 6: back-to-back read hits accept every other cycle with 1-cycle response pulses
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = 32'h4004;
    bus.cpu_req_wen   = 1'b0;
    #1;
    check("t6 c0 ready", 64'(bus.cpu_req_ready), 64'd1);
    check("t6 c0 resp", 64'(bus.cpu_resp_valid), 64'd0);
    @(negedge clk);
    bus.cpu_req_addr = 32'h2004;
    #1;
    check("t6 c1 ready", 64'(bus.cpu_req_ready), 64'd0);
    check("t6 c1 resp", 64'(bus.cpu_resp_valid), 64'd1);
    check("t6 c1 rdata", 64'(bus.cpu_resp_rdata), 64'h0BADF00D);
    @(negedge clk);
    #1;
    check("t6 c2 ready", 64'(bus.cpu_req_ready), 64'd1);
    check("t6 c2 resp", 64'(bus.cpu_resp_valid), 64'd0);
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
    #1;
    check("t6 c3 ready", 64'(bus.cpu_req_ready), 64'd0);
    check("t6 c3 resp", 64'(bus.cpu_resp_valid), 64'd1);
    check("t6 c3 rdata", 64'(bus.cpu_resp_rdata), 64'hCAFEF00D);
    @(negedge clk);
    #1;
    check("t6 c4 resp", 64'(bus.cpu_resp_valid), 64'd0);
    check("t6 c4 ready", 64'(bus.cpu_req_ready), 64'd1);
    check("t6 no mem", 64'(bus.mem_req_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
